// File: rtl/uart_word_sender.sv
// Buffers wide words in a small FIFO and feeds them byte by byte, LSB first,
// to a UART transmitter using a start pulse / done-level handshake.
module uart_word_sender #(
    parameter int LONGITUD_PALABRA   = 32,
    parameter int OUTPUT_WORD_LENGTH = 8,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_word_valid,
    input  logic [LONGITUD_PALABRA-1:0]   i_word,
    output logic                          o_word_ready,
    input  logic                          i_flush,
    input  logic                          i_tx_done,
    output logic                          o_tx_start,
    output logic [OUTPUT_WORD_LENGTH-1:0] o_data_tx,
    output logic                          o_busy,
    output logic [15:0]                   o_words_sent
);

    localparam int BYTES = LONGITUD_PALABRA / OUTPUT_WORD_LENGTH;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_LOW  = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    logic [LONGITUD_PALABRA-1:0]   fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]              wr_ptr_r;
    logic [PTR_W-1:0]              rd_ptr_r;
    logic [CNT_W-1:0]              count_r;
    logic [CNT_W-1:0]              count_next_s;
    logic                          ready_r;
    logic                          push_s;
    logic                          pop_s;

    state_t                        state_r;
    logic [LONGITUD_PALABRA-1:0]   shift_r;
    logic [LONGITUD_PALABRA-1:0]   shift_next_s;
    logic [IDX_W-1:0]              idx_r;
    logic                          tx_start_r;
    logic [OUTPUT_WORD_LENGTH-1:0] data_r;
    logic                          busy_r;
    logic [15:0]                   words_sent_r;

    // A flush wins over a same-cycle push; the FSM only pops while idle.
    assign push_s       = i_word_valid && ready_r && !i_flush;
    assign pop_s        = (state_r == IDLE) && (count_r != {CNT_W{1'b0}}) && !i_flush;
    assign shift_next_s = shift_r >> OUTPUT_WORD_LENGTH;

    // Next FIFO occupancy; push and pop together leave it unchanged.
    always_comb begin
        count_next_s = count_r;
        if (i_flush) begin
            count_next_s = {CNT_W{1'b0}};
        end else if (push_s && !pop_s) begin
            count_next_s = count_r + CNT_W'(1'b1);
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - CNT_W'(1'b1);
        end else begin
            count_next_s = count_r;
        end
    end

    // FIFO storage; contents need no reset since occupancy guards every read.
    always_ff @(posedge i_clock) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= i_word;
        end
    end

    // FIFO pointers, occupancy and the registered ready flag.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            ready_r  <= 1'b1;
        end else if (i_flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            ready_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            count_r <= count_next_s;
            ready_r <= (count_next_s != CNT_W'(FIFO_DEPTH));
        end
    end

    // Byte sequencer with registered start, data, busy and word counter.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r      <= IDLE;
            shift_r      <= {LONGITUD_PALABRA{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            tx_start_r   <= 1'b0;
            data_r       <= {OUTPUT_WORD_LENGTH{1'b0}};
            busy_r       <= 1'b0;
            words_sent_r <= 16'd0;
        end else begin
            tx_start_r <= 1'b0;
            busy_r     <= (count_next_s != {CNT_W{1'b0}});
            if (i_flush) begin
                state_r <= IDLE;
                idx_r   <= {IDX_W{1'b0}};
            end else begin
                case (state_r)
                    IDLE: begin
                        if (pop_s) begin
                            shift_r <= fifo_mem_r[rd_ptr_r];
                            idx_r   <= {IDX_W{1'b0}};
                            state_r <= LOAD;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    LOAD: begin
                        data_r     <= shift_r[OUTPUT_WORD_LENGTH-1:0];
                        tx_start_r <= 1'b1;
                        state_r    <= START;
                        busy_r     <= 1'b1;
                    end
                    START: begin
                        state_r <= WAIT_LOW;
                        busy_r  <= 1'b1;
                    end
                    WAIT_LOW: begin
                        busy_r <= 1'b1;
                        if (!i_tx_done) begin
                            state_r <= WAIT_HIGH;
                        end else begin
                            state_r <= WAIT_LOW;
                        end
                    end
                    WAIT_HIGH: begin
                        if (!i_tx_done) begin
                            state_r <= WAIT_HIGH;
                            busy_r  <= 1'b1;
                        end else if (idx_r == IDX_W'(BYTES - 1)) begin
                            words_sent_r <= words_sent_r + 16'd1;
                            state_r      <= IDLE;
                        end else begin
                            idx_r      <= idx_r + IDX_W'(1'b1);
                            shift_r    <= shift_next_s;
                            data_r     <= shift_next_s[OUTPUT_WORD_LENGTH-1:0];
                            tx_start_r <= 1'b1;
                            state_r    <= START;
                            busy_r     <= 1'b1;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_word_ready = ready_r;
    assign o_tx_start   = tx_start_r;
    assign o_data_tx    = data_r;
    assign o_busy       = busy_r;
    assign o_words_sent = words_sent_r;

endmodule

// File: tb/tb_uart_word_sender.sv
// Directed plus randomized bench for uart_word_sender; expected byte streams
// come from a word-to-bytes reference model and a responding transmitter model.
module tb_uart_word_sender;

    localparam int W  = 32;
    localparam int OW = 8;
    localparam int NB = W / OW;

    logic          i_clock;
    logic          i_reset;
    logic          i_word_valid;
    logic [W-1:0]  i_word;
    logic          o_word_ready;
    logic          i_flush;
    logic          i_tx_done;
    logic          o_tx_start;
    logic [OW-1:0] o_data_tx;
    logic          o_busy;
    logic [15:0]   o_words_sent;

    uart_word_sender #(
        .LONGITUD_PALABRA  (W),
        .OUTPUT_WORD_LENGTH(OW),
        .FIFO_DEPTH        (4)
    ) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_word_valid(i_word_valid),
        .i_word      (i_word),
        .o_word_ready(o_word_ready),
        .i_flush     (i_flush),
        .i_tx_done   (i_tx_done),
        .o_tx_start  (o_tx_start),
        .o_data_tx   (o_data_tx),
        .o_busy      (o_busy),
        .o_words_sent(o_words_sent)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    int          passed = 0;
    int          total  = 0;
    int          fails  = 0;
    logic [7:0]  cap_q[$];
    logic [7:0]  exp_q[$];
    bit          tx_hold   = 1'b0;
    int          low_cnt   = 0;
    int          start_cnt = 0;
    int          stab_err  = 0;
    bit          in_byte   = 1'b0;
    logic [7:0]  held      = 8'h00;
    logic [15:0] exp_sent  = 16'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: a word becomes NB bytes, least significant first.
    task automatic add_word(input logic [W-1:0] w);
        for (int k = 0; k < NB; k++) exp_q.push_back(8'((w >> (8 * k)) & 32'hFF));
    endtask

    task automatic push_word(input logic [W-1:0] w);
        @(negedge i_clock);
        if (o_word_ready) add_word(w);
        i_word_valid = 1'b1;
        i_word       = w;
        @(negedge i_clock);
        i_word_valid = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string tag);
        int n = 0;
        @(negedge i_clock);
        while (o_busy !== 1'b0 && n < maxc) begin
            @(negedge i_clock);
            n++;
        end
        check(tag, 32'(n < maxc), 32'd1);
    endtask

    task automatic wait_start(input int maxc, input string tag);
        int n = 0;
        @(negedge i_clock);
        while (o_tx_start !== 1'b1 && n < maxc) begin
            @(negedge i_clock);
            n++;
        end
        check(tag, 32'(n < maxc), 32'd1);
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check({tag, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_b%0d", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
        cap_q.delete();
        exp_q.delete();
    endtask

    // Transmitter model: done drops on each start and returns high after 10 cycles unless held.
    initial begin
        i_tx_done = 1'b1;
        forever begin
            @(negedge i_clock);
            if (i_reset && o_tx_start) begin
                cap_q.push_back(o_data_tx);
                start_cnt++;
                held      = o_data_tx;
                in_byte   = 1'b1;
                i_tx_done = 1'b0;
                low_cnt   = 0;
            end else begin
                if (!i_reset) in_byte = 1'b0;
                if (i_reset && in_byte && !i_tx_done && o_data_tx !== held) stab_err++;
                if (!i_tx_done && !tx_hold) begin
                    low_cnt++;
                    if (low_cnt >= 10) begin
                        i_tx_done = 1'b1;
                        low_cnt   = 0;
                        in_byte   = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] w;
        int           acc;
        int           base;
        int           n;

        i_reset = 1'b0; i_word_valid = 1'b0; i_word = '0; i_flush = 1'b0;
        repeat (3) @(negedge i_clock);
        check("rst_ready", 32'(o_word_ready), 32'd1);
        check("rst_busy",  32'(o_busy),       32'd0);
        check("rst_start", 32'(o_tx_start),   32'd0);
        check("rst_data",  32'(o_data_tx),    32'd0);
        check("rst_sent",  32'(o_words_sent), 32'd0);
        i_reset = 1'b1;
        repeat (2) @(negedge i_clock);

        // Single word: latency from push, byte order, counter.
        base = start_cnt;
        push_word(32'h11223344);
        @(negedge i_clock);
        check("lat_load", 32'(o_tx_start), 32'd0);
        @(negedge i_clock);
        check("lat_start", 32'(o_tx_start), 32'd1);
        check("lat_data",  32'(o_data_tx),  32'h44);
        wait_idle(500, "w1_idle");
        compare_stream("w1");
        check("w1_starts", 32'(start_cnt - base), 32'd4);
        exp_sent++;
        check("w1_sent", 32'(o_words_sent), 32'(exp_sent));

        // Back-to-back random pushes with the transmitter stalled.
        tx_hold = 1'b1;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clock);
            w = $urandom;
            if (o_word_ready) begin
                add_word(w);
                acc++;
            end
            i_word_valid = 1'b1;
            i_word       = w;
        end
        @(negedge i_clock);
        i_word_valid = 1'b0;
        check("full_ready", 32'(o_word_ready), 32'd0);
        check("full_accept", 32'(acc == 4 || acc == 5), 32'd1);
        push_word($urandom);
        check("full_drop_ready", 32'(o_word_ready), 32'd0);
        tx_hold = 1'b0;
        wait_idle(3000, "full_idle");
        compare_stream("full");
        exp_sent += 16'(acc);
        check("full_sent", 32'(o_words_sent), 32'(exp_sent));

        // Push coinciding with pop while three words are queued.
        tx_hold = 1'b1;
        push_word($urandom);
        for (int b = 0; b < NB; b++) begin
            wait_start(100, $sformatf("occ_start%0d", b));
            if (b == NB - 1) begin
                for (int j = 0; j < 3; j++) push_word($urandom);
            end
            repeat (2) @(negedge i_clock);
            i_tx_done = 1'b1;
        end
        @(negedge i_clock);
        w = $urandom;
        if (o_word_ready) add_word(w);
        i_word_valid = 1'b1;
        i_word       = w;
        @(negedge i_clock);
        i_word_valid = 1'b0;
        check("occ3_ready", 32'(o_word_ready), 32'd1);
        push_word($urandom);
        check("occ4_full", 32'(o_word_ready), 32'd0);
        tx_hold = 1'b0;
        wait_idle(3000, "occ_idle");
        compare_stream("occ");
        exp_sent += 16'd6;
        check("occ_sent", 32'(o_words_sent), 32'(exp_sent));

        // Flush during the second byte with two words queued behind it.
        base = start_cnt;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clock);
            i_word_valid = 1'b1;
            i_word       = $urandom;
        end
        @(negedge i_clock);
        i_word_valid = 1'b0;
        n = 0;
        while (start_cnt < base + 2 && n < 200) begin
            @(negedge i_clock);
            n++;
        end
        check("fl_second_byte", 32'(n < 200), 32'd1);
        i_flush = 1'b1; i_word_valid = 1'b1; i_word = $urandom;
        @(negedge i_clock);
        i_flush = 1'b0; i_word_valid = 1'b0;
        base = start_cnt;
        repeat (60) @(negedge i_clock);
        check("fl_no_start", 32'(start_cnt), 32'(base));
        check("fl_busy",     32'(o_busy), 32'd0);
        check("fl_ready",    32'(o_word_ready), 32'd1);
        check("fl_sent",     32'(o_words_sent), 32'(exp_sent));
        cap_q.delete();
        exp_q.delete();
        push_word($urandom);
        wait_idle(500, "fl_after_idle");
        compare_stream("fl_after");
        exp_sent++;
        check("fl_after_sent", 32'(o_words_sent), 32'(exp_sent));

        // Reset while waiting for the transmitter to go busy.
        push_word(32'hCAFEF00D);
        wait_start(100, "rs_start");
        @(negedge i_clock);
        i_reset = 1'b0;
        #1;
        check("rs_start_out", 32'(o_tx_start),   32'd0);
        check("rs_data",      32'(o_data_tx),    32'd0);
        check("rs_busy",      32'(o_busy),       32'd0);
        check("rs_sent",      32'(o_words_sent), 32'd0);
        check("rs_ready",     32'(o_word_ready), 32'd1);
        repeat (2) @(negedge i_clock);
        i_reset = 1'b1;
        cap_q.delete();
        exp_q.delete();
        exp_sent = 16'd0;
        n = 0;
        while (i_tx_done !== 1'b1 && n < 100) begin
            @(negedge i_clock);
            n++;
        end
        push_word(32'hDEADBEEF);
        wait_idle(500, "rs_idle");
        compare_stream("rs");
        exp_sent++;
        check("rs_after_sent", 32'(o_words_sent), 32'(exp_sent));

        // Counter wrap from 65535 to 0.
        @(negedge i_clock);
        force dut.words_sent_r = 16'hFFFF;
        @(negedge i_clock);
        release dut.words_sent_r;
        check("wrap_preload", 32'(o_words_sent), 32'hFFFF);
        push_word($urandom);
        wait_idle(500, "wrap_idle");
        compare_stream("wrap");
        check("wrap_sent", 32'(o_words_sent), 32'd0);

        check("data_stable", 32'(stab_err), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
